// File: rtl/nmi2ahbl_bridge.sv
// NMI slave to AHB-Lite master bridge: each NMI request becomes one or more single,
// non-pipelined AHB transfers and completes with a one-cycle ready pulse.
module nmi2ahbl_bridge #(
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        nmi_valid_i,
    input  logic [31:0] nmi_addr_i,
    input  logic [31:0] nmi_wdata_i,
    input  logic [3:0]  nmi_wstrb_i,
    output logic [31:0] nmi_rdata_o,
    output logic        nmi_ready_o,
    output logic [31:0] haddr_o,
    output logic [1:0]  htrans_o,
    output logic        hwrite_o,
    output logic [2:0]  hsize_o,
    output logic [2:0]  hburst_o,
    output logic [3:0]  hprot_o,
    output logic        hmastlock_o,
    output logic [31:0] hwdata_o,
    input  logic        hready_i,
    input  logic        hresp_i,
    input  logic [31:0] hrdata_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

    typedef struct packed {
        logic [3:0] lanes;
        logic [1:0] off;
        logic [2:0] size;
    } plan_t;

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        split_q, split_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  lanes_q, lanes_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  size_q, size_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    plan_t       pl;
    logic        addr_lo_unused;

    assign addr_lo_unused = ^nmi_addr_i[1:0];

    // Once a strobe is non-contiguous it stays split into bytes, even if the
    // remaining lanes happen to form an aligned half.
    function automatic plan_t plan_xfer(input logic [3:0] m, input logic split);
        plan_t p;
        p = '{lanes: 4'b0001, off: 2'd0, size: 3'd0};
        if (!split && m == 4'hF)      p = '{lanes: 4'b1111, off: 2'd0, size: 3'd2};
        else if (!split && m == 4'h3) p = '{lanes: 4'b0011, off: 2'd0, size: 3'd1};
        else if (!split && m == 4'hC) p = '{lanes: 4'b1100, off: 2'd2, size: 3'd1};
        else begin
            casez (m)
                4'b???1: p = '{lanes: 4'b0001, off: 2'd0, size: 3'd0};
                4'b??10: p = '{lanes: 4'b0010, off: 2'd1, size: 3'd0};
                4'b?100: p = '{lanes: 4'b0100, off: 2'd2, size: 3'd0};
                default: p = '{lanes: 4'b1000, off: 2'd3, size: 3'd0};
            endcase
        end
        return p;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        split_d = split_q;
        mask_d  = mask_q;
        lanes_d = lanes_q;
        off_d   = off_q;
        size_d  = size_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        pl      = '0;
        case (state_q)
            S_IDLE: begin
                if (nmi_valid_i) begin
                    addr_d  = nmi_addr_i[31:2];
                    wdata_d = nmi_wdata_i;
                    write_d = |nmi_wstrb_i;
                    split_d = (|nmi_wstrb_i) && !(nmi_wstrb_i == 4'hF || nmi_wstrb_i == 4'h3 ||
                              nmi_wstrb_i == 4'hC ||
                              (nmi_wstrb_i & (nmi_wstrb_i - 4'd1)) == 4'd0);
                    mask_d  = (|nmi_wstrb_i) ? nmi_wstrb_i : 4'hF;
                    pl      = plan_xfer(mask_d, split_d);
                    lanes_d = pl.lanes;
                    off_d   = pl.off;
                    size_d  = pl.size;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (hready_i) state_d = S_DATA;
            end
            S_DATA: begin
                if (hresp_i) begin
                    err_d = 1'b1;
                    if (hready_i) begin
                        mask_d  = 4'h0;
                        rdata_d = ERR_RDATA;
                        state_d = S_RESP;
                    end
                end else if (hready_i) begin
                    mask_d = mask_q & ~lanes_q;
                    if (mask_d != 4'h0) begin
                        pl      = plan_xfer(mask_d, split_q);
                        lanes_d = pl.lanes;
                        off_d   = pl.off;
                        size_d  = pl.size;
                        state_d = S_ADDR;
                    end else begin
                        rdata_d = hrdata_i;
                        state_d = S_RESP;
                    end
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            split_q <= 1'b0;
            mask_q  <= '0;
            lanes_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            split_q <= split_d;
            mask_q  <= mask_d;
            lanes_q <= lanes_d;
            off_q   <= off_d;
            size_q  <= size_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign htrans_o    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign haddr_o     = {addr_q, off_q};
    assign hwrite_o    = write_q;
    assign hsize_o     = size_q;
    assign hburst_o    = 3'b000;
    assign hprot_o     = HPROT_VAL;
    assign hmastlock_o = 1'b0;
    assign hwdata_o    = (state_q == S_DATA) ? wdata_q : 32'h0;
    assign nmi_ready_o = (state_q == S_RESP);
    assign bus_err_o   = nmi_ready_o && err_q;
    assign nmi_rdata_o = nmi_ready_o ? rdata_q : 32'h0;

endmodule

// File: tb/tb_nmi2ahbl_bridge.sv
// Directed bench for nmi2ahbl_bridge: a transfer-list model, an AHB slave emulator
// and one per-cycle compare process.
module tb_nmi2ahbl_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nmi_valid_i;
    logic [31:0] nmi_addr_i, nmi_wdata_i;
    logic [3:0]  nmi_wstrb_i;
    logic [31:0] nmi_rdata_o;
    logic        nmi_ready_o;
    logic [31:0] haddr_o;
    logic [1:0]  htrans_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o, hburst_o;
    logic [3:0]  hprot_o;
    logic        hmastlock_o;
    logic [31:0] hwdata_o;
    logic        hready_i, hresp_i;
    logic [31:0] hrdata_i;
    logic        bus_err_o;

    always #5 clk = ~clk;

    nmi2ahbl_bridge dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .nmi_valid_i(nmi_valid_i), .nmi_addr_i(nmi_addr_i), .nmi_wdata_i(nmi_wdata_i),
        .nmi_wstrb_i(nmi_wstrb_i), .nmi_rdata_o(nmi_rdata_o), .nmi_ready_o(nmi_ready_o),
        .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
        .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o),
        .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i),
        .bus_err_o(bus_err_o)
    );

    typedef struct packed {
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
    } cpl_t;

    xfer_t xq[$];
    cpl_t  cq[$];
    int    n_chk = 0;
    int    n_pass = 0;
    logic  mon_en = 1'b0;

    // slave emulator configuration and state
    int          aw = 0, dw = 0, eidx = -1, xidx = 0;
    logic [31:0] rd_val = 32'h0;
    logic        dphase = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // AHB slave: drives hready/hresp/hrdata for the current cycle just after negedge,
    // so dphase seen by the compare process at negedge describes the current cycle.
    initial begin : slave
        int  acnt, dcnt, ecnt;
        logic nd;
        acnt = 0; dcnt = 0; ecnt = 0;
        forever begin
            @(negedge clk);
            #1;
            nd = 1'b0;
            hrdata_i = 32'h0BAD_0BAD;
            if (!rst_n) begin
                acnt = 0; dcnt = 0; ecnt = 0;
                hready_i = 1'b1; hresp_i = 1'b0;
            end else if (htrans_o == 2'b10) begin
                hresp_i = 1'b0;
                if (acnt < aw) begin hready_i = 1'b0; acnt++; end
                else begin hready_i = 1'b1; acnt = 0; end
                nd = hready_i;
            end else if (dphase) begin
                if (xidx == eidx) begin
                    hresp_i = 1'b1;
                    if (ecnt == 0) begin hready_i = 1'b0; ecnt = 1; end
                    else begin hready_i = 1'b1; ecnt = 0; xidx++; end
                end else begin
                    hresp_i = 1'b0;
                    if (dcnt < dw) begin hready_i = 1'b0; dcnt++; end
                    else begin hready_i = 1'b1; dcnt = 0; xidx++; hrdata_i = rd_val; end
                end
                nd = !hready_i;
            end else begin
                hready_i = 1'b1; hresp_i = 1'b0;
            end
            dphase = nd;
        end
    end

    // Per-cycle comparison of DUT outputs against the model queues.
    initial begin : compare
        xfer_t cur;
        cpl_t  c;
        logic  prev_ns;
        cur = '0;
        prev_ns = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                prev_ns = 1'b0;
            end else begin
                chk("consts", {24'h0, hburst_o, hprot_o, hmastlock_o}, {24'h0, 3'b000, 4'b0011, 1'b0});
                if (htrans_o == 2'b10) begin
                    if (!prev_ns) begin
                        if (xq.size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_xfer: got haddr %h, required no transfer", haddr_o);
                        end else begin
                            cur = xq.pop_front();
                            chk("haddr", haddr_o, cur.haddr);
                            chk("hsize", {29'h0, hsize_o}, {29'h0, cur.hsize});
                            chk("hwrite", {31'h0, hwrite_o}, {31'h0, cur.hwrite});
                        end
                    end else begin
                        chk("stall_haddr", haddr_o, cur.haddr);
                        chk("stall_hsize", {29'h0, hsize_o}, {29'h0, cur.hsize});
                    end
                    prev_ns = 1'b1;
                end else begin
                    chk("htrans_idle", {30'h0, htrans_o}, 32'h0);
                    prev_ns = 1'b0;
                end
                if (dphase && cur.hwrite) chk("hwdata", hwdata_o, cur.wdata);
                if (nmi_ready_o) begin
                    if (cq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_ready: got ready=1, required 0");
                    end else begin
                        c = cq.pop_front();
                        chk("bus_err", {31'h0, bus_err_o}, {31'h0, c.err});
                        if (c.chk_rdata) chk("rdata", nmi_rdata_o, c.rdata);
                    end
                end else begin
                    chk("rdata_idle", nmi_rdata_o, 32'h0);
                    chk("berr_idle", {31'h0, bus_err_o}, 32'h0);
                end
            end
        end
    end

    // Model: expand a request into its AHB transfer list and completion, and derive latency.
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                         input int aw_, input int dw_, input int e_, input logic [31:0] rv,
                         output int lat, output logic [31:0] a0);
        xfer_t l[$];
        int    n;
        logic  err;
        cpl_t  c;
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        if (s == 4'h0)      l.push_back('{base, 3'd2, 1'b0, wd});
        else if (s == 4'hF) l.push_back('{base, 3'd2, 1'b1, wd});
        else if (s == 4'h3) l.push_back('{base, 3'd1, 1'b1, wd});
        else if (s == 4'hC) l.push_back('{base + 32'd2, 3'd1, 1'b1, wd});
        else for (int i = 0; i < 4; i++) if (s[i]) l.push_back('{base + i, 3'd0, 1'b1, wd});
        n   = l.size();
        err = (e_ >= 0) && (e_ < n);
        if (err) n = e_ + 1;
        lat = 1;
        for (int i = 0; i < n; i++) begin
            xq.push_back(l[i]);
            lat += 1 + aw_ + ((err && i == n - 1) ? 2 : 1 + dw_);
        end
        a0 = l[0].haddr;
        c.err = err;
        c.rdata = err ? 32'hDEAD_BEEF : rv;
        c.chk_rdata = err || (s == 4'h0);
        cq.push_back(c);
    endtask

    task automatic do_req(input string nm, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] s, input int aw_, input int dw_, input int e_,
                          input logic [31:0] rv, input int lit_lat, input logic [31:0] lit_a0);
        int lat_m, cnt;
        logic [31:0] a0;
        @(negedge clk);
        model(a, wd, s, aw_, dw_, e_, rv, lat_m, a0);
        chk({nm, "_model_lat"}, lat_m, lit_lat);
        chk({nm, "_model_a0"}, a0, lit_a0);
        aw = aw_; dw = dw_; eidx = e_; rd_val = rv; xidx = 0;
        nmi_valid_i = 1'b1; nmi_addr_i = a; nmi_wdata_i = wd; nmi_wstrb_i = s;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                nmi_addr_i = ~a; nmi_wdata_i = ~wd; nmi_wstrb_i = ~s;
            end
        end while (!nmi_ready_o && cnt < 60);
        if (!nmi_ready_o) begin
            n_chk++;
            $display("FAIL %s_timeout: got no ready in %0d cycles, required ready", nm, cnt);
        end
        nmi_valid_i = 1'b0;
        chk({nm, "_lat"}, cnt, lit_lat);
    endtask

    initial begin : stim
        int cnt;
        int lat_m;
        logic [31:0] a0;
        rst_n = 1'b0; nmi_valid_i = 1'b0; nmi_addr_i = '0; nmi_wdata_i = '0; nmi_wstrb_i = '0;
        hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_htrans", {30'h0, htrans_o}, 32'h0);
        chk("rst_ready", {31'h0, nmi_ready_o}, 32'h0);
        chk("rst_haddr", haddr_o, 32'h0);
        chk("rst_hwrite_hsize", {28'h0, hwrite_o, hsize_o}, 32'h0);
        chk("rst_hwdata", hwdata_o, 32'h0);
        chk("rst_rdata_berr", {nmi_rdata_o[30:0], bus_err_o}, 32'h0);
        chk("rst_hprot", {28'h0, hprot_o}, 32'h3);
        rst_n = 1'b1;
        mon_en = 1'b1;

        //       name     addr          wdata         strb   aw dw err rdata         lat a0
        do_req("rd",    32'h1000_0004, 32'h0,        4'h0, 0, 0, -1, 32'h1234_5678, 3, 32'h1000_0004);
        do_req("wr_hi", 32'h2000_0000, 32'hAABB_CCDD, 4'hC, 0, 0, -1, 32'h0,        3, 32'h2000_0002);
        do_req("wr_05", 32'h3000_0001, 32'h1122_3344, 4'h5, 0, 0, -1, 32'h0,        5, 32'h3000_0000);
        do_req("rd_w3", 32'h4000_0008, 32'h0,        4'h0, 0, 3, -1, 32'hCAFE_F00D, 6, 32'h4000_0008);
        do_req("rd_a2", 32'h4000_0013, 32'h0,        4'h0, 2, 0, -1, 32'h0F0F_0F0F, 5, 32'h4000_0010);
        do_req("wr_err",32'h5000_0000, 32'h5555_AAAA, 4'hB, 0, 0, 0,  32'h0,        4, 32'h5000_0000);
        do_req("wr_w",  32'h6000_0006, 32'h0102_0304, 4'hF, 0, 0, -1, 32'h0,        3, 32'h6000_0004);
        do_req("wr_07", 32'h7000_0000, 32'h7777_7777, 4'h7, 0, 0, -1, 32'h0,        7, 32'h7000_0000);
        do_req("wr_0d", 32'h7000_0010, 32'hDDDD_0000, 4'hD, 0, 0, -1, 32'h0,        7, 32'h7000_0010);
        do_req("wr_b1", 32'h8000_0000, 32'h0000_AB00, 4'h2, 0, 0, -1, 32'h0,        3, 32'h8000_0001);
        do_req("wr_lo", 32'h9000_0000, 32'h0000_BEEF, 4'h3, 0, 1, -1, 32'h0,        4, 32'h9000_0000);
        do_req("wr_e1", 32'hA000_0000, 32'h0066_6600, 4'h6, 0, 0, 1,  32'h0,        6, 32'hA000_0001);

        // Reset during the data phase aborts without a completion.
        @(negedge clk);
        model(32'hB000_0000, 32'h0, 4'h0, 0, 8, -1, 32'h1, lat_m, a0);
        aw = 0; dw = 8; eidx = -1; xidx = 0;
        nmi_valid_i = 1'b1; nmi_addr_i = 32'hB000_0000; nmi_wstrb_i = 4'h0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!dphase && cnt < 10);
        chk("rst_mid_reached_data", {31'h0, dphase}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_htrans", {30'h0, htrans_o}, 32'h0);
        chk("rst_mid_ready", {31'h0, nmi_ready_o}, 32'h0);
        nmi_valid_i = 1'b0;
        xq.delete();
        cq.delete();
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_ready", {31'h0, nmi_ready_o}, 32'h0);
        end
        rst_n = 1'b1;
        do_req("rd_post", 32'hC000_0000, 32'h0, 4'h0, 0, 0, -1, 32'h600D_D00D, 3, 32'hC000_0000);

        repeat (4) @(negedge clk);
        chk("xq_drained", xq.size(), 32'h0);
        chk("cq_drained", cq.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
